inv_mix_columns_seq: RTL
========================

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

Interface
REQ-001 Parameters: none; the state width is fixed at 128 bits and the column width at 32 bits.
REQ-002 Clocking: the block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_state is valid.
REQ-006 in_ready  output  1  block can accept a state.
REQ-007 in_state  input  128  AES state; byte 0 = [127:120]; column c = bits [127-32c : 96-32c], top byte = row 0.
REQ-008 out_valid  output  1  out_state holds a result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_state  output  128  InvMixColumns(in_state), same byte ordering.

Function
REQ-011 Each column SHALL be multiplied over GF(2^8), reduction 0x1B, by rows [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
REQ-012 Constant products SHALL come from an xtime chain: x2=xtime(a), x4=xtime(x2), x8=xtime(x4); 09=x8^a, 0b=x8^x2^a, 0d=x8^x4^a, 0e=x8^x4^x2.
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 IDLE: in_ready=1; in_valid at a clock edge captures in_state, clears col_cnt to 0, and moves to BUSY.
REQ-015 BUSY: in_ready=0; each edge transforms column col_cnt in place and increments the 2-bit col_cnt; the edge processing column 3 moves to DONE.
REQ-016 Latency: the accept edge is T; columns are processed on T+1..T+4; out_valid SHALL be high from just after T+4.
REQ-017 DONE: out_valid=1 and out_state is stable; the state SHALL be held indefinitely while out_ready=0.
REQ-018 In DONE, out_ready=1 at an edge SHALL complete the transfer and return to IDLE; a new input SHALL NOT be accepted on that same edge.
REQ-019 in_valid in BUSY or DONE SHALL be ignored and SHALL NOT disturb the result.
REQ-020 Throughput SHALL be at most one state per 6 cycles with no backpressure.
REQ-021 out_state SHALL equal the working register in all states; its value is defined only while out_valid=1.

Reset
REQ-022 While rst_n=0: state=IDLE, col_cnt=0, working register=0, in_ready=1, out_valid=0, out_state=0.
REQ-023 Reset asserted in BUSY or DONE SHALL abort the operation immediately and discard any partial result.
REQ-024 After deassertion, the first edge with in_valid=1 SHALL be accepted normally.

Structure
REQ-025 The shared AES package SHALL hold: FSM state encoding, reduction constant 8'h1B, and the inverse coefficients 8'h0E, 8'h0B, 8'h0D, 8'h09.
REQ-026 Sub-module gf_inv_column_mult SHALL be purely combinational: 32-bit column in, 32-bit column out, interface mirroring the forward column multiplier; exactly one instance, muxed by col_cnt.
REQ-027 Estimated RTL size: 150-250 lines, sub-module included.

Verification
REQ-028 Single state: in_state = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_state = db135345_f20a225c_01010101_d4d4d4d5, with out_valid rising exactly 4 edges after the accept edge.
REQ-029 Column vectors: 4d7ebdf8 -> 2d26314c; c6c6c6c6 -> c6c6c6c6 (run as full states with the other columns 0 -> 0).
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE on the next edge.
REQ-031 Reset mid-op: assert rst_n=0 on the edge after processing column 1 -> out_valid=0 and in_ready=1 immediately; a following state then produces the correct full result.
REQ-032 Round trip: 1000 random states through the forward MixColumns reference model, then this block -> output equals the original state.
REQ-033 Back-to-back: in_valid held high with out_ready=1 -> one accept every 6 cycles and every result correct.

Source files
------------

// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared AES definitions for the sequential InvMixColumns block: FSM encoding,
// GF(2^8) reduction constant, inverse coefficients and constant-multiply helpers.
package inv_mix_columns_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [7:0] GfPoly   = 8'h1B;
   localparam logic [7:0] InvCoefE = 8'h0E;
   localparam logic [7:0] InvCoefB = 8'h0B;
   localparam logic [7:0] InvCoefD = 8'h0D;
   localparam logic [7:0] InvCoef9 = 8'h09;

   // Multiply by x modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GfPoly : 8'h00);
   endfunction

   // Constant multiply built from the xtime chain; only the four inverse
   // coefficients are meaningful.
   function automatic logic [7:0] gf_mul_inv(input logic [7:0] a, input logic [7:0] coef);
      logic [7:0] x2, x4, x8, p;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (coef)
         InvCoef9: p = x8 ^ a;
         InvCoefB: p = x8 ^ x2 ^ a;
         InvCoefD: p = x8 ^ x4 ^ a;
         InvCoefE: p = x8 ^ x4 ^ x2;
         default:  p = 8'h00;
      endcase
      return p;
   endfunction

   // Matrix row r is [0e 0b 0d 09] rotated right by r; k = (col - row) mod 4.
   function automatic logic [7:0] inv_coef(input logic [1:0] k);
      logic [7:0] c;
      case (k)
         2'd0:    c = InvCoefE;
         2'd1:    c = InvCoefB;
         2'd2:    c = InvCoefD;
         default: c = InvCoef9;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bus for the InvMixColumns block: input state channel and output
// result channel, each valid/ready.
interface inv_mix_columns_seq_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport master (
      output in_valid,
      input  in_ready,
      output in_state,
      input  out_valid,
      output out_ready,
      input  out_state
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_state,
      output out_valid,
      input  out_ready,
      output out_state
   );

endinterface

// File: rtl/gf_inv_column_mult.sv
// Combinational InvMixColumns of one 32-bit column; top byte is row 0.
module gf_inv_column_mult
   import inv_mix_columns_seq_pkg::*;
(
   input  logic [31:0] i_col,
   output logic [31:0] o_col
);

   logic [7:0] w_a [4];
   logic [7:0] w_b [4];

   // Split the column into bytes, row 0 at the top.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         w_a[j] = i_col[31 - 8*j -: 8];
      end
   end

   // Each output row is the XOR of the coefficient products across the column.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         w_b[r] = 8'h00;
         for (int j = 0; j < 4; j++) begin
            w_b[r] = w_b[r] ^ gf_mul_inv(w_a[j], inv_coef(2'(j - r)));
         end
      end
   end

   assign o_col = {w_b[0], w_b[1], w_b[2], w_b[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: captures a 128-bit state, transforms one column per
// cycle in place through a single shared column multiplier, then holds the
// result until the consumer takes it.
module inv_mix_columns_seq
   import inv_mix_columns_seq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   inv_mix_columns_seq_if.slave    bus
);

   state_e       r_state;
   logic [1:0]   r_col_cnt;
   logic [127:0] r_work;
   logic         r_in_ready;
   logic         r_out_valid;

   logic [31:0]  w_col_in;
   logic [31:0]  w_col_out;
   logic [127:0] w_work_upd;

   // Select the column currently being processed; column 0 is the top word.
   always_comb begin
      w_col_in = r_work[127:96];
      case (r_col_cnt)
         2'd0: w_col_in = r_work[127:96];
         2'd1: w_col_in = r_work[95:64];
         2'd2: w_col_in = r_work[63:32];
         2'd3: w_col_in = r_work[31:0];
      endcase
   end

   gf_inv_column_mult u_col_mult (
      .i_col (w_col_in),
      .o_col (w_col_out)
   );

   // Write the transformed column back into its slot, leaving the others.
   always_comb begin
      w_work_upd = r_work;
      case (r_col_cnt)
         2'd0: w_work_upd[127:96] = w_col_out;
         2'd1: w_work_upd[95:64]  = w_col_out;
         2'd2: w_work_upd[63:32]  = w_col_out;
         2'd3: w_work_upd[31:0]   = w_col_out;
      endcase
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_col_cnt   <= 2'd0;
         r_work      <= 128'h0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (bus.in_valid) begin
                  r_work     <= bus.in_state;
                  r_col_cnt  <= 2'd0;
                  r_in_ready <= 1'b0;
                  r_state    <= StBusy;
               end
            end
            StBusy: begin
               r_work    <= w_work_upd;
               r_col_cnt <= r_col_cnt + 2'd1;
               if (r_col_cnt == 2'd3) begin
                  r_out_valid <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               // Returning to idle here keeps in_ready low on this edge, so no
               // new state is taken on the same edge as the transfer.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_state     <= StIdle;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_state = r_work;

endmodule
